// File: rtl/keying_modulator.sv
// ASK / FSK / BPSK keying modulator: DDS sine carrier keyed by a PRBS symbol stream.
// Define KEYMOD_EXT_DATA_EN to replace the internal PRBS with an external data_in/data_req pair.
module keying_modulator #(
  parameter int DAC_W   = 10,
  parameter int LUT_AW  = 8,
  parameter int PHASE_W = 24,
  parameter int LFSR_N  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] fword0,
  input  logic [PHASE_W-1:0] fword1,
  input  logic [15:0]        sym_div,
`ifdef KEYMOD_EXT_DATA_EN
  input  logic               data_in,
  output logic               data_req,
`endif
  output logic [DAC_W-1:0]   dac_out,
  output logic               bit_out,
  output logic               sym_strobe
);

  typedef enum logic [1:0] {
    MODE_ASK  = 2'b00,
    MODE_FSK  = 2'b01,
    MODE_BPSK = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  localparam int                TBL     = 1 << LUT_AW;
  localparam logic [DAC_W-1:0]  MID     = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [LUT_AW-1:0] HALF    = {1'b1, {(LUT_AW-1){1'b0}}};
  localparam longint            PI_Q30  = 64'sd3373259426;

  // Elaboration-time sine: quarter-wave folding plus a Q30 Taylor series.
  function automatic logic [DAC_W-1:0] sine_entry(input int k);
    int     q, kk, quad, j;
    longint x, x2, term, s, amp, mag;
    q    = TBL / 4;
    kk   = k % TBL;
    quad = kk / q;
    j    = kk % q;
    if (quad == 1 || quad == 3) j = q - j;
    x    = (PI_Q30 * longint'(j)) / longint'(2 * q);
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    amp = longint'(MID) - 64'sd1;
    mag = (amp * s + (64'sd1 <<< 29)) >>> 30;
    return (quad >= 2) ? DAC_W'(longint'(MID) - mag) : DAC_W'(longint'(MID) + mag);
  endfunction

  // NOTE: the sine ROM is pure constant logic and carries no reset; only state registers are reset.
  logic [DAC_W-1:0] lut [TBL];
  for (genvar k = 0; k < TBL; k++) begin : g_lut
    localparam logic [DAC_W-1:0] ENTRY = sine_entry(k);
    assign lut[k] = ENTRY;
  end

  logic [15:0]        sym_cnt;
  logic [15:0]        sym_lim;
  logic               wrap;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc;
  mode_e              mode_q;

  // A period of zero would strobe every cycle; the minimum period is two cycles.
  assign sym_lim = (sym_div == 16'd0) ? 16'd1 : sym_div;
  assign wrap    = enable && (sym_cnt >= sym_lim);
  assign inc     = (mode_q == MODE_FSK && bit_out) ? fword1 : fword0;

  // NOTE: non-blocking assignments make every register update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt    <= '0;
      sym_strobe <= 1'b0;
      mode_q     <= MODE_OFF;
      phase      <= '0;
    end else begin
      sym_strobe <= wrap;
      if (wrap) mode_q <= mode_e'(mode);
      if (enable) begin
        sym_cnt <= wrap ? 16'd0 : sym_cnt + 16'd1;
        phase   <= phase + inc;
      end
    end
  end

`ifdef KEYMOD_EXT_DATA_EN
  logic bit_q;

  always_ff @(posedge clk) begin
    if (rst)       bit_q <= 1'b1;
    else if (wrap) bit_q <= data_in;
  end

  assign bit_out  = bit_q;
  assign data_req = sym_strobe;
`else
  localparam int TAP = (LFSR_N == 7) ? 6 : (LFSR_N == 9) ? 5 : 14;
  logic [LFSR_N-1:0] lfsr;

  // The all-zero lock-up state is escaped by reloading all-ones.
  always_ff @(posedge clk) begin
    if (rst)               lfsr <= '1;
    else if (lfsr == '0)   lfsr <= '1;
    else if (wrap)         lfsr <= {lfsr[LFSR_N-2:0], lfsr[LFSR_N-1] ^ lfsr[TAP-1]};
  end

  assign bit_out = lfsr[LFSR_N-1];
`endif

  logic [LUT_AW-1:0] addr_d, addr_q;
  logic              act_d, act_q;

  assign addr_d = phase[PHASE_W-1 -: LUT_AW]
                + ((mode_q == MODE_BPSK && !bit_out) ? HALF : '0);
  assign act_d  = enable && (mode_q != MODE_OFF) && !(mode_q == MODE_ASK && !bit_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      act_q   <= 1'b0;
      dac_out <= MID;
    end else begin
      addr_q  <= addr_d;
      act_q   <= act_d;
      dac_out <= act_q ? lut[addr_q] : MID;
    end
  end

endmodule

// File: tb/tb_keying_modulator.sv
// Self-checking bench for keying_modulator (default build, PRBS7 source).
module tb_keying_modulator;

  localparam logic [1:0] M_ASK = 2'b00, M_FSK = 2'b01, M_BPSK = 2'b10, M_OFF = 2'b11;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [1:0]  mode;
  logic [23:0] fword0, fword1;
  logic [15:0] sym_div;
  logic [9:0]  dac_out;
  logic        bit_out, sym_strobe;

  always #5 clk = ~clk;

  keying_modulator #(.DAC_W(10), .LUT_AW(8), .PHASE_W(24), .LFSR_N(7)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .fword0(fword0), .fword1(fword1), .sym_div(sym_div),
    .dac_out(dac_out), .bit_out(bit_out), .sym_strobe(sym_strobe)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_cnt    = 0;
  logic [6:0]  m_lfsr   = 7'h7F;
  logic [1:0]  m_mq     = M_OFF;
  logic [23:0] m_phase  = '0;
  logic        m_strobe = 1'b0;
  int          sb[$];

  function automatic int ref_sine(input int k);
    real v;
    v = 511.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
    if (v >= 0.0) return 512 + $rtoi($floor(v + 0.5));
    else          return 512 - $rtoi($floor(-v + 0.5));
  endfunction

  function automatic int exp_now();
    logic [7:0] a;
    logic       b;
    b = m_lfsr[6];
    if (!enable || m_mq == M_OFF || (m_mq == M_ASK && !b)) return 512;
    a = m_phase[23:16];
    if (m_mq == M_BPSK && !b) a = a + 8'd128;
    return ref_sine(int'(a));
  endfunction

  task automatic model_step();
    int          lim;
    logic        wrap;
    logic [23:0] inc;
    if (rst) begin
      m_cnt = 0; m_lfsr = 7'h7F; m_mq = M_OFF; m_phase = '0; m_strobe = 1'b0;
    end else begin
      lim      = (sym_div == 16'd0) ? 1 : int'(sym_div);
      wrap     = enable && (m_cnt >= lim);
      inc      = (m_mq == M_FSK && m_lfsr[6]) ? fword1 : fword0;
      m_strobe = wrap;
      if (enable) begin
        m_cnt   = wrap ? 0 : m_cnt + 1;
        m_phase = m_phase + inc;
      end
      if (m_lfsr == 7'h00) m_lfsr = 7'h7F;
      else if (wrap)       m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      if (wrap) m_mq = mode;
    end
  endtask

  // One clock: expected sample of this cycle enters the scoreboard, popped two cycles later.
  task automatic tick();
    if (!rst) sb.push_back(exp_now());
    model_step();
    @(posedge clk);
    #1;
    check("strobe", sym_strobe, m_strobe);
    check("bit", bit_out, m_lfsr[6]);
    if (rst) begin
      sb.delete();
      check("rst_dac", dac_out, 512);
      check("rst_bit", bit_out, 1);
      check("rst_strobe", sym_strobe, 0);
    end else if (sb.size() >= 2) begin
      check("dac", dac_out, sb.pop_front());
    end
  endtask

  typedef struct {
    logic [1:0]       mode;
    int               k;
    logic             bitv;
    logic [3:0][9:0]  exp;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] m, input int k, input logic b,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.mode = m; v.k = k; v.bitv = b;
    v.exp[0] = 10'(e0); v.exp[1] = 10'(e1); v.exp[2] = 10'(e2); v.exp[3] = 10'(e3);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   c, ns, s1, found, nonmid, ones, last;
    int   bits[$];
    int   eb[254];
    logic [6:0] s;

    rst = 1'b1; enable = 1'b1; mode = M_ASK; fword0 = 24'h400000; fword1 = 24'h100000; sym_div = 16'd3;

    vecs[0] = mk(M_ASK,  1, 1'b1, 512, 1023, 512, 1);
    vecs[1] = mk(M_ASK,  7, 1'b0, 512, 512,  512, 512);
    vecs[2] = mk(M_BPSK, 1, 1'b1, 512, 1023, 512, 1);
    vecs[3] = mk(M_BPSK, 7, 1'b0, 512, 1,    512, 1023);
    vecs[4] = mk(M_OFF,  1, 1'b1, 512, 512,  512, 512);
    vecs[5] = mk(M_OFF,  7, 1'b0, 512, 512,  512, 512);

    // Table: quarter-turn carrier from phase 0, checked on the symbol of the k-th strobe.
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode; fword0 = 24'h400000; fword1 = 24'h100000; sym_div = 16'd3; enable = 1'b1;
      do_reset();
      c = 0; ns = 0; s1 = -1; found = 0;
      for (int t = 0; t < 100; t++) begin
        tick(); c++;
        if (sym_strobe) begin
          ns++;
          if (ns == 1) s1 = c;
        end
        if (s1 < 0 || c <= s1 + 1) check($sformatf("v%0d_pre_mid", i), dac_out, 512);
        if (ns == vecs[i].k) begin found = 1; break; end
      end
      check($sformatf("v%0d_strobe_seen", i), found, 1);
      check($sformatf("v%0d_bit", i), bit_out, vecs[i].bitv);
      if (found == 1) begin
        tick(); c++;
        for (int j = 0; j < 4; j++) begin
          tick(); c++;
          check($sformatf("v%0d_sample%0d", i, j), dac_out, vecs[i].exp[(c - 2) % 4]);
        end
      end
    end

    // PRBS7: period-4 strobes, bit sequence against an independent LFSR, repeat at 127.
    s = 7'h7F;
    for (int i = 0; i < 254; i++) begin
      s = {s[5:0], s[6] ^ s[5]};
      eb[i] = int'(s[6]);
    end
    mode = M_ASK; fword0 = 24'h400000; sym_div = 16'd3;
    do_reset();
    c = 0; last = -1;
    for (int t = 0; t < 1100 && bits.size() < 254; t++) begin
      tick(); c++;
      if (sym_strobe) begin
        if (last >= 0) check("strobe_period", c - last, 4);
        last = c;
        bits.push_back(int'(bit_out));
      end
    end
    check("prbs_strobe_count", bits.size(), 254);
    if (bits.size() == 254) begin
      for (int i = 0; i < 6; i++) check($sformatf("prbs_first%0d", i), bits[i], 1);
      check("prbs_seventh", bits[6], 0);
      ones = 0;
      for (int i = 0; i < 127; i++) begin
        check("prbs_seq", bits[i], eb[i]);
        check("prbs_repeat", bits[i + 127], eb[i]);
        ones += bits[i];
      end
      check("prbs_ones", ones, 64);
    end

    // FSK: eighth/quarter turn steps, phase carried across boundaries (scoreboard).
    mode = M_FSK; fword0 = 24'h200000; fword1 = 24'h400000;
    repeat (120) tick();

    // ASK -> off mid-symbol: current symbol completes, midscale from next strobe + 2.
    mode = M_ASK; fword0 = 24'h400000;
    ns = 0; found = 0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (sym_strobe) begin
        ns++;
        if (ns >= 2 && bit_out) begin found = 1; break; end
      end
    end
    check("ask_bit1_symbol_found", found, 1);
    tick();
    mode = M_OFF;
    nonmid = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (dac_out != 10'd512) nonmid++;
      if (j == 2) check("modechg_next_strobe", sym_strobe, 1);
    end
    check("modechg_old_mode_held", (nonmid > 0) ? 1 : 0, 1);
    tick(); check("modechg_mid0", dac_out, 512);
    tick(); check("modechg_mid1", dac_out, 512);

    // Mid-symbol reset pulse.
    mode = M_ASK;
    repeat (9) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();

    // Period shrink below the current count wraps on the next cycle; sym_div=0 acts as 1.
    sym_div = 16'd7; found = 0;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (sym_strobe) begin found = 1; break; end
    end
    check("div7_strobe_found", found, 1);
    repeat (5) tick();
    sym_div = 16'd2;
    tick(); check("shrink_wrap", sym_strobe, 1);
    sym_div = 16'd0;
    tick(); check("div0_s0", sym_strobe, 0);
    tick(); check("div0_s1", sym_strobe, 1);
    tick(); check("div0_s2", sym_strobe, 0);
    tick(); check("div0_s3", sym_strobe, 1);

    // Enable low: counters hold, pipeline drains to midscale.
    sym_div = 16'd3; mode = M_BPSK;
    repeat (12) tick();
    enable = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("dis_no_strobe", sym_strobe, 0);
    end
    check("dis_mid", dac_out, 512);
    enable = 1'b1;
    repeat (30) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
